msx_fdc_drive_ctrl: RTL

- Parametrised drive-control front end for MSX WD17xx-based disk cartridges; sits between the decoded cartridge register window and the FDC core.
- Supports 1-4 drives with a side register, drive-select/motor register and FDC status mirror.
- Provides a motor retrigger/timeout timer, spin-up delay, per-drive index pulse generation and read-to-clear disk-change latches.
- Outputs feed the FDC core's ready/side inputs and the image/SD selection logic.

---
 rtl/msx_fdc_drive_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/msx_fdc_drive_ctrl.sv
// -----------------------------------------------------------------------------
// msx_fdc_drive_ctrl
//
// Drive-control front end for MSX WD17xx disk cartridges. It sits between the
// decoded 4-byte cartridge register window and the FDC core. It holds the
// side and drive-select/motor registers, mirrors the FDC DRQ/INTRQ lines,
// runs the spindle motor state machine (spin-up, run, coast with timeout),
// generates the per-drive index pulse and keeps read-to-clear disk-change
// latches.
//
// Optional feature macro: FDC_DSKCHG_EN
//   defined   : disk-change latches exist; register 2 returns them and a read
//               of register 2 clears them.
//   undefined : no latches; register 2 reads 8'hFF with no side effects.
//
// Ports
//   clk_sys      system clock
//   reset        asynchronous active-high reset
//   ce_ms        one-cycle 1 kHz strobe, all ms timers advance on it
//   cs/addr      register window select and offset
//   rd/wr        one-cycle CPU read/write strobes
//   din/dout     CPU write data / combinational register read data
//   output_rq    dout valid (cs & rd)
//   fdc_access   any CPU access to the FDC core, retriggers the coast timer
//   fdc_drq      FDC data request (mirrored inverted in register 3)
//   fdc_intrq    FDC interrupt request (mirrored inverted in register 3)
//   img_present  per-drive level: image mounted and non-empty
//   img_mounted  per-drive one-cycle mount/eject pulse
//   drive_sel    selected drive number
//   side         head side
//   motor_on     spindle motor running
//   fdc_ready    ready to the FDC core (registered)
//   index        index pulse to the FDC core
// -----------------------------------------------------------------------------
module msx_fdc_drive_ctrl #(
    parameter int DRIVES           = 2,
    parameter int MOTOR_TIMEOUT_MS = 3000,
    parameter int SPINUP_MS        = 250,
    parameter int INDEX_PERIOD_MS  = 200,
    parameter int INDEX_WIDTH_MS   = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_ms,
    input  logic              cs,
    input  logic [1:0]        addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              output_rq,
    input  logic              fdc_access,
    input  logic              fdc_drq,
    input  logic              fdc_intrq,
    input  logic [DRIVES-1:0] img_present,
    input  logic [DRIVES-1:0] img_mounted,
    output logic [1:0]        drive_sel,
    output logic              side,
    output logic              motor_on,
    output logic              fdc_ready,
    output logic              index
);

    localparam int CW = 16;
    localparam logic [1:0]    MAX_SEL     = 2'(DRIVES - 1);
    localparam logic [CW-1:0] SPIN_LAST   = CW'(SPINUP_MS - 1);
    localparam logic [CW-1:0] COAST_LOAD  = CW'(MOTOR_TIMEOUT_MS);
    localparam logic [CW-1:0] INDEX_LAST  = CW'(INDEX_PERIOD_MS - 1);
    localparam logic [CW-1:0] INDEX_WIDTH = CW'(INDEX_WIDTH_MS);

    typedef enum logic [1:0] {
        MOTOR_OFF,
        MOTOR_SPINUP,
        MOTOR_RUN,
        MOTOR_COAST
    } motor_state_e;

    motor_state_e  state_q, state_d;
    logic          side_q, side_d;
    logic [1:0]    driveSel_q, driveSel_d;
    logic          motorReq_q, motorReq_d;
    logic [CW-1:0] spinCnt_q, spinCnt_d;
    logic [CW-1:0] coastCnt_q, coastCnt_d;
    logic [CW-1:0] idxCnt_q, idxCnt_d;
    logic          fdcReady_q, fdcReady_d;
    logic          index_q, index_d;

    logic          wrSide;
    logic          wrDrive;
    logic          motorOnWr;
    logic [1:0]    selWr;
    logic [3:0]    presPad;
    logic [7:0]    dchgRead;
    logic          unusedBits;

    // Register window decode. All four offsets are readable registers.
    assign wrSide    = cs & wr & (addr == 2'd0);
    assign wrDrive   = cs & wr & (addr == 2'd1);
    assign motorOnWr = wrDrive & din[7];
    assign selWr     = (din[1:0] > MAX_SEL) ? MAX_SEL : din[1:0];
    assign output_rq = cs & rd;

    // Zero-extend img_present so any 2-bit drive number indexes safely.
    assign presPad   = 4'(img_present);

    assign unusedBits = ^din[6:2];

    assign side      = side_q;
    assign drive_sel = driveSel_q;
    assign motor_on  = (state_q != MOTOR_OFF);
    assign fdc_ready = fdcReady_q;
    assign index     = index_q;

`ifdef FDC_DSKCHG_EN
    logic [DRIVES-1:0] dchg_q, dchg_d;
    logic              rdDchg;

    assign rdDchg   = cs & rd & (addr == 2'd2);
    assign dchgRead = {{(8 - DRIVES){1'b1}}, dchg_q};

    // A clearing read and a mount pulse in the same cycle: the mount wins so
    // the event is never lost.
    always_comb begin
        dchg_d = dchg_q;
        if (rdDchg) begin
            dchg_d = '0;
        end
        dchg_d = dchg_d | img_mounted;
    end

    // Latches come up set so software always sees a change after reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dchg_q <= '1;
        end else begin
            dchg_q <= dchg_d;
        end
    end
`else
    logic unusedMounted;

    assign dchgRead      = 8'hFF;
    assign unusedMounted = ^img_mounted;
`endif

    // Combinational register read mux; idle bus reads as all ones.
    always_comb begin
        dout = 8'hFF;
        if (output_rq) begin
            case (addr)
                2'd0:    dout = {7'b0, side_q};
                2'd1:    dout = {motorReq_q, 5'b0, driveSel_q};
                2'd2:    dout = dchgRead;
                default: dout = {~fdc_drq, ~fdc_intrq, 6'b111111};
            endcase
        end
    end

    // CPU-writable registers.
    always_comb begin
        side_d     = side_q;
        driveSel_d = driveSel_q;
        motorReq_d = motorReq_q;
        if (wrSide) begin
            side_d = din[0];
        end
        if (wrDrive) begin
            driveSel_d = selWr;
            motorReq_d = din[7];
        end
    end

    // Motor state machine. Spin-up always runs to completion; if the request
    // was dropped meanwhile, the motor goes straight into the coast phase.
    // In COAST a re-request resumes RUN without a new spin-up, and any FDC
    // access restarts the timeout.
    always_comb begin
        state_d    = state_q;
        spinCnt_d  = spinCnt_q;
        coastCnt_d = coastCnt_q;
        case (state_q)
            MOTOR_OFF: begin
                spinCnt_d  = '0;
                coastCnt_d = '0;
                if (motorOnWr) begin
                    state_d = MOTOR_SPINUP;
                end
            end
            MOTOR_SPINUP: begin
                if (ce_ms) begin
                    if (spinCnt_q == SPIN_LAST) begin
                        spinCnt_d = '0;
                        if (motorReq_q) begin
                            state_d = MOTOR_RUN;
                        end else begin
                            state_d    = MOTOR_COAST;
                            coastCnt_d = COAST_LOAD;
                        end
                    end else begin
                        spinCnt_d = spinCnt_q + 1'b1;
                    end
                end
            end
            MOTOR_RUN: begin
                if (!motorReq_q) begin
                    state_d    = MOTOR_COAST;
                    coastCnt_d = COAST_LOAD;
                end
            end
            MOTOR_COAST: begin
                if (motorOnWr) begin
                    state_d = MOTOR_RUN;
                end else if (fdc_access) begin
                    coastCnt_d = COAST_LOAD;
                end else if (ce_ms) begin
                    if (coastCnt_q <= 1) begin
                        state_d    = MOTOR_OFF;
                        coastCnt_d = '0;
                    end else begin
                        coastCnt_d = coastCnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = MOTOR_OFF;
            end
        endcase
    end

    // Ready and index. Ready lags the state by one cycle; index follows the
    // next-state values so it drops the moment the motor stops.
    always_comb begin
        idxCnt_d = idxCnt_q;
        if (state_q == MOTOR_OFF) begin
            idxCnt_d = '0;
        end else if (ce_ms) begin
            idxCnt_d = (idxCnt_q == INDEX_LAST) ? '0 : idxCnt_q + 1'b1;
        end
        fdcReady_d = ((state_q == MOTOR_RUN) || (state_q == MOTOR_COAST)) &
                     presPad[driveSel_q];
        index_d    = (state_d != MOTOR_OFF) & (idxCnt_d < INDEX_WIDTH) &
                     presPad[driveSel_d];
    end

    // State and register storage.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= MOTOR_OFF;
            side_q     <= 1'b0;
            driveSel_q <= 2'd0;
            motorReq_q <= 1'b0;
            spinCnt_q  <= '0;
            coastCnt_q <= '0;
            idxCnt_q   <= '0;
            fdcReady_q <= 1'b0;
            index_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_q     <= side_d;
            driveSel_q <= driveSel_d;
            motorReq_q <= motorReq_d;
            spinCnt_q  <= spinCnt_d;
            coastCnt_q <= coastCnt_d;
            idxCnt_q   <= idxCnt_d;
            fdcReady_q <= fdcReady_d;
            index_q    <= index_d;
        end
    end

endmodule
